// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO behind the UART receiver: stores {break, data} per
// received pulse and presents the oldest entry first-word-fall-through.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter bit KEEP_BREAK   = 1'b1,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_break,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_break,
  output logic [ADDR_W:0]         level,
  output logic                    full,
  output logic                    overflow,
  input  logic                    ovf_clear,
  input  logic                    flush
);

  localparam int WORD_W = PAYLOAD_BITS + 1;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Handshake: the head entry transfers on any edge where out_valid and out_ready
  // are both high; out_valid never depends on out_ready. in_valid has no back-pressure.
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              empty, push, pop, wr_en, drop;
  logic [WORD_W-1:0] head_word;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = ~empty;
  assign head_word = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign out_data  = out_valid ? head_word[PAYLOAD_BITS-1:0] : '0;
  assign out_break = out_valid & head_word[PAYLOAD_BITS];
  assign overflow  = overflow_q;

  always_comb begin
    push       = in_valid & (KEEP_BREAK | ~in_break) & ~flush;
    pop        = ~empty & out_ready & ~flush;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    wr_en      = push & (~full | pop);
    drop       = push & full & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {in_break, in_data};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (BREAK kept / discarded) share stimulus and
// are checked every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  localparam int PB    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          in_valid, in_break, out_ready, ovf_clear, flush;
  logic [PB-1:0] in_data;

  logic          out_valid_a [2];
  logic [PB-1:0] out_data_a  [2];
  logic          out_break_a [2];
  logic [AW:0]   level_a     [2];
  logic          full_a      [2];
  logic          overflow_a  [2];

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .KEEP_BREAK(1'b1)) dut_keep (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_break(in_break), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .out_data(out_data_a[0]), .out_break(out_break_a[0]), .level(level_a[0]),
    .full(full_a[0]), .overflow(overflow_a[0]), .ovf_clear(ovf_clear), .flush(flush)
  );

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .KEEP_BREAK(1'b0)) dut_drop (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_break(in_break), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .out_data(out_data_a[1]), .out_break(out_break_a[1]), .level(level_a[1]),
    .full(full_a[1]), .overflow(overflow_a[1]), .ovf_clear(ovf_clear), .flush(flush)
  );

  // scoreboard state
  logic [PB:0] exp_q [2][$];
  bit          model_ovf [2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[inst%0d] t=%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // monitor + reference model: compare current outputs, then apply this cycle's inputs
  always @(negedge clk) begin
    int          sz;
    bit          keep, push, pop, drop;
    logic [PB:0] head;
    for (int k = 0; k < 2; k++) begin
      keep = (k == 0);
      if (!resetn) begin
        exp_q[k].delete();
        model_ovf[k] = 1'b0;
      end
      sz = exp_q[k].size();
      check("out_valid", k, 32'(out_valid_a[k]), 32'(sz != 0));
      check("level",     k, 32'(level_a[k]),     32'(sz));
      check("full",      k, 32'(full_a[k]),      32'(sz == DEPTH));
      check("overflow",  k, 32'(overflow_a[k]),  32'(model_ovf[k]));
      if (sz != 0) begin
        head = exp_q[k][0];
        check("out_data",  k, 32'(out_data_a[k]),  32'(head[PB-1:0]));
        check("out_break", k, 32'(out_break_a[k]), 32'(head[PB]));
      end else begin
        check("idle_data",  k, 32'(out_data_a[k]),  32'd0);
        check("idle_break", k, 32'(out_break_a[k]), 32'd0);
      end
      if (resetn) begin
        push = in_valid && (keep || !in_break) && !flush;
        pop  = (sz != 0) && out_ready && !flush;
        drop = 1'b0;
        if (flush) begin
          exp_q[k].delete();
        end else begin
          drop = push && (sz == DEPTH) && !pop;
          if (pop) void'(exp_q[k].pop_front());
          if (push && !drop) exp_q[k].push_back({in_break, in_data});
        end
        if (drop) model_ovf[k] = 1'b1;
        else if (ovf_clear) model_ovf[k] = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step(input logic v, input logic [PB-1:0] d, input logic b,
                      input logic r, input logic fl, input logic oc);
    in_valid  = v;
    in_data   = d;
    in_break  = b;
    out_ready = r;
    flush     = fl;
    ovf_clear = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r, 1'b0, 1'b0);
  endtask

  task automatic push_char(input logic [PB-1:0] d, input logic b, input logic r);
    step(1'b1, d, b, r, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_break = 1'b0;
    out_ready = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(2, 1'b0);

    // three back-to-back characters, then drain
    push_char(8'h41, 1'b0, 1'b0);
    push_char(8'h42, 1'b0, 1'b0);
    push_char(8'h43, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // fill, overflow on 0xAA, drain, clear sticky flag
    for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'b0);
    push_char(8'hAA, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(DEPTH + 2, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_char(8'h10 + 8'(i), 1'b0, 1'b0);
    push_char(8'h55, 1'b0, 1'b1);
    idle(1, 1'b0);
    // drop together with ovf_clear: set wins
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    idle(DEPTH + 2, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // BREAK character
    push_char(8'h00, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // flush with a coincident character, overflow left set beforehand
    for (int i = 0; i < DEPTH + 1; i++) push_char(8'hC0 + 8'(i), 1'b0, 1'b0);
    idle(DEPTH - 5, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // push/pop across pointer wrap
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0,
           1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // randomized phase with alternating consumer speed and one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) resetn = 1'b0;
      if (i == 301) resetn = 1'b1;
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
           ((i / 60) % 2 == 1) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(DEPTH + 3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
